evt_counter_bank: RTL

Bank of `CHANNELS` independent event counters with runtime-programmable modulus, up/down direction, wrap or saturate limit behaviour, parallel load, and a registered terminal-count pulse per channel. It generalises the single free-running event counter: same one-event-per-cycle counting, but now multi-channel, width-parametrised and mode-selectable. It serves as the shared counting primitive for UART baud/bit tracking and Game Boy timer-style dividers, feeding downstream logic that needs both the live count and an overflow strobe.

---
 rtl/evt_counter_pkg.sv | 16 +
 rtl/evt_counter_chan.sv | 66 ++++++
 rtl/evt_counter_bank.sv | 38 +++
 3 files changed

// File: rtl/evt_counter_pkg.sv
// Shared types and defaults for the event counter bank.
package evt_counter_pkg;

  localparam int DEFAULT_WIDTH = 17;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    LIMIT_WRAP = 1'b0,
    LIMIT_SAT  = 1'b1
  } limit_e;

endpackage

// File: rtl/evt_counter_chan.sv
// One event counter channel: programmable modulus, up/down, wrap/saturate,
// parallel load and a registered terminal-count pulse.
module evt_counter_chan
  import evt_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             evt_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  input  logic [WIDTH-1:0] max_in,
  input  logic             dir_in,
  input  logic             sat_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out
);

  dir_e             dir;
  limit_e           limit;
  logic [WIDTH-1:0] next_count;
  logic             next_tc;

  assign dir   = dir_e'(dir_in);
  assign limit = limit_e'(sat_in);

  // Limit checks always precede the +/-1 so no value ever leaves WIDTH bits.
  always_comb begin
    next_count = count_out;
    next_tc    = 1'b0;
    if (load_in) begin
      next_count = (load_val_in > max_in) ? max_in : load_val_in;
    end else if (evt_in) begin
      if (dir == DIR_UP) begin
        if (count_out >= max_in) begin
          next_tc    = 1'b1;
          next_count = (limit == LIMIT_SAT) ? max_in : '0;
        end else begin
          next_count = count_out + 1'b1;
        end
      end else begin
        if (count_out > max_in) begin
          // Max was lowered below the live count: clamp silently.
          next_count = max_in;
        end else if (count_out == '0) begin
          next_tc    = 1'b1;
          next_count = (limit == LIMIT_SAT) ? '0 : max_in;
        end else begin
          next_count = count_out - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_out <= '0;
      tc_out    <= 1'b0;
    end else begin
      count_out <= next_count;
      tc_out    <= next_tc;
    end
  end

endmodule

// File: rtl/evt_counter_bank.sv
// Bank of independent event counters; the top only slices the packed buses
// into per-channel instances.
module evt_counter_bank
  import evt_counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CHANNELS-1:0]       evt_in,
  input  logic [CHANNELS-1:0]       load_in,
  input  logic [CHANNELS*WIDTH-1:0] load_val_in,
  input  logic [CHANNELS*WIDTH-1:0] max_in,
  input  logic [CHANNELS-1:0]       dir_in,
  input  logic [CHANNELS-1:0]       sat_in,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       tc_out
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    evt_counter_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .evt_in      (evt_in[ch]),
      .load_in     (load_in[ch]),
      .load_val_in (load_val_in[ch*WIDTH +: WIDTH]),
      .max_in      (max_in[ch*WIDTH +: WIDTH]),
      .dir_in      (dir_in[ch]),
      .sat_in      (sat_in[ch]),
      .count_out   (count_out[ch*WIDTH +: WIDTH]),
      .tc_out      (tc_out[ch])
    );
  end

endmodule
